// File: rtl/telemetry_stats_reporter.sv
// Per-window link statistics for the stream-13 counter checker: snapshots the packet counters
// every window and serialises a 12-byte status frame onto a valid/ready byte stream.
module telemetry_stats_reporter #(
  parameter logic [31:0] g_window_cnt = 32'd256000000,
  parameter logic [7:0]  g_sync_byte  = 8'hA5
) (
  input  logic        clk_256M,
  input  logic        rst_n,
  input  logic [31:0] total_packets,
  input  logic [31:0] mismatch_packets,
  input  logic        okay_led,
  input  logic        link_count_okay,
  input  logic        counters_cleared,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        window_pulse,
  output logic [15:0] frames_dropped
);

  localparam logic [31:0] LastCnt    = g_window_cnt - 32'd1;
  localparam logic [31:0] PreLastCnt = g_window_cnt - 32'd2;
  localparam logic [3:0]  LastByte   = 4'd11;

  typedef enum logic {StIdle, StSend} state_e;

  state_e      r_state;
  logic [31:0] r_win_cnt;
  logic        r_window_pulse;
  logic        r_snap;
  logic [31:0] r_prev_total;
  logic [31:0] r_prev_mis;
  logic [7:0]  r_seq;
  logic        r_drop_flag;
  logic [15:0] r_frames_dropped;
  logic [3:0]  r_byte_idx;
  logic [87:0] r_frame;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;

  logic [31:0] w_d_total;
  logic [31:0] w_d_mis;
  logic [7:0]  w_seq_next;
  logic [7:0]  w_flags;
  logic [7:0]  w_chk;
  logic        w_accept;

  assign w_d_total  = total_packets - r_prev_total;
  assign w_d_mis    = mismatch_packets - r_prev_mis;
  assign w_seq_next = r_seq + 8'd1;
  assign w_flags    = {5'b00000, r_drop_flag, link_count_okay, okay_led};
  assign w_chk      = w_seq_next ^ w_flags
                    ^ w_d_total[31:24] ^ w_d_total[23:16] ^ w_d_total[15:8] ^ w_d_total[7:0]
                    ^ w_d_mis[31:24]   ^ w_d_mis[23:16]   ^ w_d_mis[15:8]   ^ w_d_mis[7:0];
  assign w_accept   = r_tx_valid && tx_ready;

  // Pulse is registered one count early so it lines up with count g_window_cnt-1.
  always_ff @(posedge clk_256M or negedge rst_n) begin
    if (!rst_n) begin
      r_win_cnt      <= 32'd0;
      r_window_pulse <= 1'b0;
      r_snap         <= 1'b0;
    end else begin
      r_win_cnt      <= (r_win_cnt == LastCnt) ? 32'd0 : r_win_cnt + 32'd1;
      r_window_pulse <= (r_win_cnt == PreLastCnt);
      r_snap         <= r_window_pulse;
    end
  end

  // A clear coinciding with a snapshot still yields deltas from the old baseline.
  always_ff @(posedge clk_256M or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_total <= 32'd0;
      r_prev_mis   <= 32'd0;
      r_seq        <= 8'd0;
    end else begin
      if (counters_cleared) begin
        r_prev_total <= 32'd0;
        r_prev_mis   <= 32'd0;
      end else if (r_snap) begin
        r_prev_total <= total_packets;
        r_prev_mis   <= mismatch_packets;
      end
      if (r_snap) begin
        r_seq <= w_seq_next;
      end
    end
  end

  always_ff @(posedge clk_256M or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= StIdle;
      r_drop_flag      <= 1'b0;
      r_frames_dropped <= 16'd0;
      r_byte_idx       <= 4'd0;
      r_frame          <= 88'd0;
      r_tx_data        <= 8'd0;
      r_tx_valid       <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (r_snap) begin
            r_state     <= StSend;
            r_drop_flag <= 1'b0;
            r_byte_idx  <= 4'd0;
            r_frame     <= {w_seq_next, w_flags, w_d_total, w_d_mis, w_chk};
            r_tx_data   <= g_sync_byte;
            r_tx_valid  <= 1'b1;
          end
        end
        StSend: begin
          // Busy at a window end: the frame in flight wins and this window is lost.
          if (r_snap) begin
            r_drop_flag <= 1'b1;
            if (r_frames_dropped != 16'hFFFF) begin
              r_frames_dropped <= r_frames_dropped + 16'd1;
            end
          end
          if (w_accept) begin
            if (r_byte_idx == LastByte) begin
              r_state    <= StIdle;
              r_byte_idx <= 4'd0;
              r_tx_data  <= 8'd0;
              r_tx_valid <= 1'b0;
            end else begin
              r_byte_idx <= r_byte_idx + 4'd1;
              r_tx_data  <= r_frame[87:80];
              r_frame    <= {r_frame[79:0], 8'h00};
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign tx_data        = r_tx_data;
  assign tx_valid       = r_tx_valid;
  assign window_pulse   = r_window_pulse;
  assign frames_dropped = r_frames_dropped;

endmodule

// File: tb/tb_telemetry_stats_reporter.sv
// Bench for telemetry_stats_reporter: frame-level reference model plus table rows and
// hand-written stall, wrap, clear and reset sequences.
module tb_telemetry_stats_reporter;

  localparam int Win = 100;
  localparam logic [7:0] Sync = 8'hA5;

  logic        clk_256M = 1'b0;
  logic        rst_n;
  logic [31:0] total_packets;
  logic [31:0] mismatch_packets;
  logic        okay_led;
  logic        link_count_okay;
  logic        counters_cleared;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        window_pulse;
  logic [15:0] frames_dropped;

  always #5 clk_256M = ~clk_256M;

  telemetry_stats_reporter #(
    .g_window_cnt(32'(Win)),
    .g_sync_byte (Sync)
  ) u_dut (
    .clk_256M        (clk_256M),
    .rst_n           (rst_n),
    .total_packets   (total_packets),
    .mismatch_packets(mismatch_packets),
    .okay_led        (okay_led),
    .link_count_okay (link_count_okay),
    .counters_cleared(counters_cleared),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .window_pulse    (window_pulse),
    .frames_dropped  (frames_dropped)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Stimulus controls
  int          ready_mode;  // 0 always ready, 1 random, 2 stalled
  logic [31:0] inc_t, inc_m;
  logic        clr_req, rand_stim;

  // Reference model state
  int          m_wc;
  logic        m_pulse_prev;
  logic [31:0] m_prev_t, m_prev_m;
  logic [7:0]  m_seq;
  logic        m_dflag, m_busy, m_stall;
  logic [15:0] m_drops;
  logic [7:0]  m_stall_data;
  logic [7:0]  m_exp[$];
  int          m_idx;
  int          frames_rx = 0;
  logic [7:0]  cur_frame[12];
  logic [7:0]  last_frame[12];

  typedef struct {
    int          ready_mode;
    logic [31:0] inc_t;
    logic [31:0] inc_m;
    logic        ok;
    logic        lk;
    logic [31:0] dt;
    logic [31:0] dm;
    logic [7:0]  flags;
  } row_t;

  row_t rows[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    n_fails++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  function automatic logic [31:0] rx_word(input int base);
    return {last_frame[base], last_frame[base+1], last_frame[base+2], last_frame[base+3]};
  endfunction

  // Frame-level model: sampled mid-cycle, expected bytes queued per window snapshot.
  task automatic monitor();
    logic [7:0]  fb[12];
    logic [7:0]  x;
    logic [31:0] dt, dm;
    forever begin
      @(negedge clk_256M);
      if (!rst_n) begin
        m_wc = 0; m_pulse_prev = 0; m_prev_t = 0; m_prev_m = 0; m_seq = 0;
        m_dflag = 0; m_busy = 0; m_drops = 0; m_exp.delete(); m_idx = 0;
        m_stall = 0; m_stall_data = 0;
      end else begin
        check("tx_valid", 32'(tx_valid), 32'(m_busy));
        check("frames_dropped", 32'(frames_dropped), 32'(m_drops));
        check("window_pulse", 32'(window_pulse), (m_wc == Win - 1) ? 32'd1 : 32'd0);
        if (m_stall) begin
          check("hold_valid", 32'(tx_valid), 32'd1);
          check("hold_data", 32'(tx_data), 32'(m_stall_data));
        end
        if (m_pulse_prev) begin
          m_seq++;
          if (!m_busy) begin
            dt = total_packets - m_prev_t;
            dm = mismatch_packets - m_prev_m;
            fb[0] = Sync;
            fb[1] = m_seq;
            fb[2] = {5'b00000, m_dflag, link_count_okay, okay_led};
            for (int i = 0; i < 4; i++) begin
              fb[3+i] = dt[31-8*i -: 8];
              fb[7+i] = dm[31-8*i -: 8];
            end
            x = 8'h00;
            for (int i = 1; i <= 10; i++) x ^= fb[i];
            fb[11] = x;
            for (int i = 0; i < 12; i++) m_exp.push_back(fb[i]);
            m_busy = 1; m_dflag = 0; m_idx = 0;
          end else begin
            if (m_drops != 16'hFFFF) m_drops++;
            m_dflag = 1;
          end
          m_prev_t = counters_cleared ? 32'd0 : total_packets;
          m_prev_m = counters_cleared ? 32'd0 : mismatch_packets;
        end else if (counters_cleared) begin
          m_prev_t = 0;
          m_prev_m = 0;
        end
        if (tx_valid && tx_ready) begin
          if (m_exp.size() == 0) begin
            fail_now("extra_byte", $sformatf("got byte %h, expected no byte", tx_data));
          end else begin
            check("frame_byte", 32'(tx_data), 32'(m_exp.pop_front()));
            if (m_idx < 12) cur_frame[m_idx] = tx_data;
            m_idx++;
            if (m_idx >= 12) begin
              last_frame = cur_frame;
              frames_rx++;
              m_busy = 0;
              m_idx = 0;
            end
          end
        end
        m_stall = tx_valid && !tx_ready;
        m_stall_data = tx_data;
        m_pulse_prev = (m_wc == Win - 1);
        m_wc = (m_wc == Win - 1) ? 0 : m_wc + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk_256M);
    #1;
    if (clr_req) begin
      total_packets = 32'd0;
      mismatch_packets = 32'd0;
      counters_cleared = 1'b1;
      clr_req = 1'b0;
    end else begin
      counters_cleared = 1'b0;
      total_packets += inc_t;
      mismatch_packets += inc_m;
    end
    if (rand_stim) begin
      inc_t = $urandom;
      inc_m = 32'($urandom_range(0, 3));
      okay_led = 1'($urandom_range(0, 1));
      link_count_okay = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) clr_req = 1'b1;
    end
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b0;
    endcase
  endtask

  // Leaves the bench in the snapshot cycle just after a window_pulse.
  task automatic sync_window();
    int n = 0;
    while (!window_pulse && n < 2 * Win) begin
      step();
      n++;
    end
    if (!window_pulse) fail_now("window_timeout", "no window_pulse within 200 cycles");
    step();
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_rx < target && n < 300) begin
      step();
      n++;
    end
    if (frames_rx < target)
      fail_now("frame_timeout", $sformatf("got %0d frames, expected %0d", frames_rx, target));
  endtask

  initial begin
    int          nf;
    int          n;
    logic [7:0]  s;
    logic [31:0] exp_t, exp_m;

    rows[0] = '{0, 32'd1,          32'd0,          1'b1, 1'b0, 32'h00000064, 32'h00000000, 8'h01};
    rows[1] = '{1, 32'd1,          32'd0,          1'b1, 1'b0, 32'h00000064, 32'h00000000, 8'h01};
    rows[2] = '{0, 32'd3,          32'd1,          1'b0, 1'b1, 32'h0000012C, 32'h00000064, 8'h02};
    rows[3] = '{1, 32'h01000000,   32'd2,          1'b1, 1'b1, 32'h64000000, 32'h000000C8, 8'h03};
    rows[4] = '{0, 32'h0FFFFFFF,   32'hFFFFFFFF,   1'b0, 1'b0, 32'h3FFFFF9C, 32'hFFFFFF9C, 8'h00};

    rst_n = 1'b0;
    total_packets = 0; mismatch_packets = 0; okay_led = 1'b1; link_count_okay = 1'b0;
    counters_cleared = 1'b0; tx_ready = 1'b1;
    ready_mode = 0; inc_t = 32'd1; inc_m = 32'd0; clr_req = 1'b0; rand_stim = 1'b0;

    fork
      monitor();
    join_none

    repeat (3) step();
    check("reset_valid", 32'(tx_valid), 32'd0);
    check("reset_data", 32'(tx_data), 32'd0);
    check("reset_pulse", 32'(window_pulse), 32'd0);
    check("reset_drops", 32'(frames_dropped), 32'd0);
    rst_n = 1'b1;
    sync_window();

    // Each row owns two windows; the frame of the first one is fully under its settings.
    for (int r = 0; r < 5; r++) begin
      ready_mode = rows[r].ready_mode;
      inc_t = rows[r].inc_t;
      inc_m = rows[r].inc_m;
      okay_led = rows[r].ok;
      link_count_okay = rows[r].lk;
      sync_window();
      nf = frames_rx;
      wait_frames(nf + 1);
      check($sformatf("row%0d_sync", r), 32'(last_frame[0]), 32'(Sync));
      check($sformatf("row%0d_flags", r), 32'(last_frame[2]), 32'(rows[r].flags));
      check($sformatf("row%0d_d_total", r), rx_word(3), rows[r].dt);
      check($sformatf("row%0d_d_mis", r), rx_word(7), rows[r].dm);
      sync_window();
    end

    // Sink stalls 250 cycles from frame start: two windows lost.
    ready_mode = 2; inc_t = 32'd1; inc_m = 32'd0; okay_led = 1'b1; link_count_okay = 1'b0;
    nf = frames_rx;
    step();
    s = m_seq;
    repeat (249) step();
    ready_mode = 0;
    wait_frames(nf + 1);
    check("stall_seq", 32'(last_frame[1]), 32'(s));
    check("stall_drops", 32'(frames_dropped), 32'd2);
    wait_frames(nf + 2);
    check("gap_seq", 32'(last_frame[1]), 32'(s + 8'd3));
    check("gap_drop_flag", 32'(last_frame[2][2]), 32'd1);
    wait_frames(nf + 3);
    check("after_gap_seq", 32'(last_frame[1]), 32'(s + 8'd4));
    check("after_gap_drop_flag", 32'(last_frame[2][2]), 32'd0);

    // Counter wraps through 2^32 inside one window.
    sync_window();
    ready_mode = 1; inc_t = 32'd0; inc_m = 32'd0;
    total_packets = 32'hFFFFFFF0;
    repeat (30) step();
    total_packets = 32'h00000010;
    sync_window();
    nf = frames_rx;
    wait_frames(nf + 1);
    check("wrap_d_total", rx_word(3), 32'h00000020);

    // Checker clear mid-window followed by exactly 40 packets.
    sync_window();
    ready_mode = 0; inc_t = 32'd1;
    repeat (20) step();
    clr_req = 1'b1;
    step();
    repeat (40) step();
    inc_t = 32'd0;
    sync_window();
    nf = frames_rx;
    wait_frames(nf + 1);
    check("clear_d_total", rx_word(3), 32'h00000028);
    check("clear_d_mis", rx_word(7), 32'h00000000);

    // Free-running random traffic, random sink, random clears and flags.
    rand_stim = 1'b1; ready_mode = 1;
    repeat (6) sync_window();
    rand_stim = 1'b0;

    // Asynchronous reset in the middle of byte 5.
    sync_window();
    ready_mode = 1; inc_t = 32'd1; inc_m = 32'd0; okay_led = 1'b1; link_count_okay = 1'b1;
    n = 0;
    while (m_idx < 5 && n < 200) begin
      step();
      n++;
    end
    if (m_idx < 5) fail_now("byte5_timeout", "frame never reached byte 5");
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(tx_valid), 32'd0);
    check("async_reset_data", 32'(tx_data), 32'd0);
    check("async_reset_drops", 32'(frames_dropped), 32'd0);
    total_packets = 32'd0;
    mismatch_packets = 32'd7;
    repeat (3) step();
    rst_n = 1'b1;
    sync_window();
    exp_t = total_packets;
    exp_m = mismatch_packets;
    nf = frames_rx;
    wait_frames(nf + 1);
    check("post_reset_seq", 32'(last_frame[1]), 32'd1);
    check("post_reset_flags", 32'(last_frame[2]), 32'h03);
    check("post_reset_d_total", rx_word(3), exp_t);
    check("post_reset_d_mis", rx_word(7), exp_m);
    check("post_reset_drops", 32'(frames_dropped), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
